// File: rtl/clkctrl_phi2_multi_pkg.sv
// Shared types and default sizes for the PHI2 clock generator.
package clkctrl_pkg;

  localparam int DEF_DEL_DEPTH = 4;
  localparam int DEF_TAP_W     = 2;
  localparam int DEF_DIV_W     = 3;

  typedef enum logic [1:0] {
    LS_RUN  = 2'd0,
    HS_RUN  = 2'd1,
    HS_PARK = 2'd2
  } state_e;

endpackage

// File: rtl/clkctrl_phi2_multi_if.sv
// Control/status bundle between the host-side bus logic and the clock generator.
interface clkctrl_phi2_multi_if
  import clkctrl_pkg::*;
#(
  parameter int TAP_W = DEF_TAP_W,
  parameter int DIV_W = DEF_DIV_W
);
  logic             lsclk_in;
  logic             hsclk_sel;
  logic [TAP_W-1:0] delay_sel;
  logic [DIV_W-1:0] div_sel;
  logic             clkout;
  logic             hsclk_selected;
  logic             lsclk_selected;
  logic             switch_busy;

  modport master (
    output lsclk_in, hsclk_sel, delay_sel, div_sel,
    input  clkout, hsclk_selected, lsclk_selected, switch_busy
  );

  modport slave (
    input  lsclk_in, hsclk_sel, delay_sel, div_sel,
    output clkout, hsclk_selected, lsclk_selected, switch_busy
  );
endinterface

// File: rtl/clkctrl_phi2_multi_delay.sv
// Host clock sampler: shift pipe with selectable tap and edge detect on the tapped value.
module lsclk_delay_line #(
  parameter int DEL_DEPTH = 4,
  parameter int TAP_W     = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_b,
  input  logic             i_lsclk,
  input  logic [TAP_W-1:0] i_delay_sel,
  output logic             o_ls_del,
  output logic             o_ls_rise,
  output logic             o_ls_fall
);
  logic [DEL_DEPTH-1:0] r_del_q;
  logic                 r_ls_prev;
  logic                 w_ls_del;

  // New samples enter at the top bit; tap k is DEL_DEPTH-k cycles old.
  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_del_q   <= '0;
      r_ls_prev <= 1'b0;
    end else begin
      r_del_q   <= (r_del_q >> 1) | (DEL_DEPTH'(i_lsclk) << (DEL_DEPTH - 1));
      r_ls_prev <= w_ls_del;
    end
  end

  // Out-of-range taps fall back to tap 0.
  always_comb begin
    w_ls_del = r_del_q[0];
    for (int k = 1; k < DEL_DEPTH; k++)
      if (int'(i_delay_sel) == k) w_ls_del = r_del_q[k];
  end

  assign o_ls_del  = w_ls_del;
  assign o_ls_rise = w_ls_del & ~r_ls_prev;
  assign o_ls_fall = ~w_ls_del & r_ls_prev;
endmodule

// File: rtl/clkctrl_phi2_multi.sv
// Single-clock CPU clock generator: switches glitch-free between the delayed host
// clock and a programmable divider of hsclk_in, parking high across a switch.
module clkctrl_phi2_multi
  import clkctrl_pkg::*;
#(
  parameter int DEL_DEPTH = DEF_DEL_DEPTH,
  parameter int TAP_W     = DEF_TAP_W,
  parameter int DIV_W     = DEF_DIV_W
) (
  input logic                 i_hsclk_in,
  input logic                 i_rst_b,
  clkctrl_phi2_multi_if.slave bus
);
  state_e           r_state, w_state_n;
  logic             r_clkout, w_clk_n;
  logic [DIV_W-1:0] r_cnt, w_cnt_n;
  logic [DIV_W-1:0] r_div_q, w_div_n;
  logic             w_ls_del, w_ls_rise, w_ls_fall;

  lsclk_delay_line #(.DEL_DEPTH(DEL_DEPTH), .TAP_W(TAP_W)) u_delay (
    .i_clk      (i_hsclk_in),
    .i_rst_b    (i_rst_b),
    .i_lsclk    (bus.lsclk_in),
    .i_delay_sel(bus.delay_sel),
    .o_ls_del   (w_ls_del),
    .o_ls_rise  (w_ls_rise),
    .o_ls_fall  (w_ls_fall)
  );

  always_ff @(posedge i_hsclk_in) begin
    if (!i_rst_b) begin
      r_state  <= LS_RUN;
      r_clkout <= 1'b0;
      r_cnt    <= '0;
      r_div_q  <= '0;
    end else begin
      r_state  <= w_state_n;
      r_clkout <= w_clk_n;
      r_cnt    <= w_cnt_n;
      r_div_q  <= w_div_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_clk_n   = r_clkout;
    w_cnt_n   = r_cnt;
    w_div_n   = r_div_q;
    case (r_state)
      LS_RUN: begin
        w_clk_n = w_ls_del;
        // Enter HS only on a host rising edge so the high level is already in place.
        if (bus.hsclk_sel && w_ls_rise) begin
          w_state_n = HS_RUN;
          w_clk_n   = 1'b1;
          w_cnt_n   = bus.div_sel;
          w_div_n   = bus.div_sel;
        end
      end
      HS_RUN: begin
        if (r_cnt != '0) begin
          w_cnt_n = r_cnt - DIV_W'(1);
        end else if (!r_clkout) begin
          w_clk_n = 1'b1;
          w_cnt_n = bus.div_sel;
          w_div_n = bus.div_sel;
        end else if (bus.hsclk_sel) begin
          w_clk_n = 1'b0;
          w_cnt_n = r_div_q;
        end else begin
          w_state_n = HS_PARK;
        end
      end
      HS_PARK: begin
        w_clk_n = 1'b1;
        if (w_ls_fall) begin
          w_state_n = LS_RUN;
          w_clk_n   = 1'b0;
        end else if (bus.hsclk_sel) begin
          w_state_n = HS_RUN;
          w_clk_n   = 1'b0;
          w_cnt_n   = r_div_q;
        end
      end
      default: begin
        w_state_n = LS_RUN;
        w_clk_n   = 1'b0;
      end
    endcase
  end

  assign bus.clkout         = r_clkout;
  assign bus.hsclk_selected = (r_state == HS_RUN);
  assign bus.lsclk_selected = (r_state == LS_RUN);
  assign bus.switch_busy    = (r_state == HS_PARK) ||
                              ((r_state == LS_RUN) &&  bus.hsclk_sel) ||
                              ((r_state == HS_RUN) && !bus.hsclk_sel);
endmodule
